// File: rtl/i2s_master_ctrl.sv
// I2S bus-master timing controller: derives sclk/lrclk from clk, starts and
// stops only on frame boundaries and relatches the divider once per frame.
module i2s_master_ctrl #(
    parameter int DIV_W  = 8,
    parameter int SLOT_W = 32,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    output logic              sclk,
    output logic              lrclk,
    output logic              frame_start,
    output logic              running,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int BC_W = $clog2(2 * SLOT_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * SLOT_W - 1);
    localparam logic [BC_W-1:0] BC_HALF = BC_W'(SLOT_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t             state_q, state_d;
    logic               sclk_q, sclk_d;
    logic               lrclk_q, lrclk_d;
    logic               frame_start_q, frame_start_d;
    logic               running_q, running_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DIV_W-1:0]   hc_q, hc_d;
    logic [BC_W-1:0]    bc_q, bc_d;
    logic [DIV_W-1:0]   div_q, div_d;

    logic [DIV_W-1:0]   div_eff;
    logic [BC_W-1:0]    bc_inc;

    always_comb begin
        div_eff = (div == '0) ? DIV_W'(1) : div;
        bc_inc  = (bc_q == BC_LAST) ? '0 : bc_q + BC_W'(1);

        state_d       = state_q;
        sclk_d        = sclk_q;
        lrclk_d       = lrclk_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        hc_d          = hc_q;
        bc_d          = bc_q;
        div_d         = div_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d       = ST_RUN;
                    sclk_d        = 1'b0;
                    lrclk_d       = 1'b0;
                    hc_d          = '0;
                    bc_d          = '0;
                    div_d         = div_eff;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (state_q == ST_RUN && !en) begin
                    state_d = ST_STOPPING;
                end else if (state_q == ST_STOPPING && en) begin
                    state_d = ST_RUN;
                end

                if (hc_q == div_q) begin
                    hc_d   = '0;
                    sclk_d = ~sclk_q;
                    // bit index and word select advance only on sclk falling
                    if (sclk_q) begin
                        bc_d    = bc_inc;
                        lrclk_d = (bc_inc >= BC_HALF);
                        if (bc_inc == '0) begin
                            // en sampled on the wrap edge itself decides stop vs. new frame
                            if (state_q == ST_STOPPING && !en) begin
                                state_d = ST_IDLE;
                                lrclk_d = 1'b1;
                                bc_d    = '0;
                            end else begin
                                frame_start_d = 1'b1;
                                frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
                                div_d         = div_eff;
                            end
                        end
                    end
                end else begin
                    hc_d = hc_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                lrclk_d = 1'b1;
                hc_d    = '0;
                bc_d    = '0;
            end
        endcase

        running_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sclk_q        <= 1'b0;
            lrclk_q       <= 1'b1;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
            frame_cnt_q   <= '0;
            hc_q          <= '0;
            bc_q          <= '0;
            div_q         <= '0;
        end else begin
            state_q       <= state_d;
            sclk_q        <= sclk_d;
            lrclk_q       <= lrclk_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
            frame_cnt_q   <= frame_cnt_d;
            hc_q          <= hc_d;
            bc_q          <= bc_d;
            div_q         <= div_d;
        end
    end

    assign sclk        = sclk_q;
    assign lrclk       = lrclk_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
